// File: rtl/f2w_hbm_wr_sched_if.sv
// Command/response bundle between the F2W HBM write scheduler and the
// broadcast HBM write-address channels. The master drives commands and
// consumes merged write responses.
interface f2w_hbm_wr_sched_if #(
  parameter int ADDR_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_len;
  logic              cmd_is_scale;
  logic              cmd_last;
  logic              bresp_valid;
  logic              bresp_err;

  modport master (
    output cmd_valid, cmd_addr, cmd_len, cmd_is_scale, cmd_last,
    input  cmd_ready, bresp_valid, bresp_err
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, cmd_is_scale, cmd_last,
    output cmd_ready, bresp_valid, bresp_err
  );
endinterface

// File: rtl/f2w_hbm_wr_sched.sv
// Write-command scheduler for one converted weight matrix on the
// Feature2Weight -> HBM path. Per output row it emits the contiguous
// sequence [WT grp0 | scale0 | WT grp1 | scale1 | ... | last WT | last scale],
// splitting weight bursts at MAX_BURST beats and at 4 KB boundaries, limits
// outstanding commands to OUTST and reports completion once every command
// has been answered.
module f2w_hbm_wr_sched #(
  parameter int ADDR_W     = 32,
  parameter int CH_W       = 16,
  parameter int BEAT_BYTES = 32,
  parameter int GROUP_CH   = 2048,
  parameter int MAX_BURST  = 16,
  parameter int OUTST      = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        cfg_base,
  input  logic [CH_W-1:0]          cfg_chin,
  input  logic [CH_W-1:0]          cfg_rows,
  f2w_hbm_wr_sched_if.master       cmd_if,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  // INT4 weights: two channels per byte, so one beat carries BEAT_BYTES*2 channels.
  localparam int CH_PER_BEAT  = BEAT_BYTES * 2;
  localparam int GRP_BEATS_I  = GROUP_CH / CH_PER_BEAT;
  localparam int RBW          = $clog2(GRP_BEATS_I + 1);
  localparam int OW           = $clog2(OUTST + 1);
  localparam int OFF_LSB      = $clog2(BEAT_BYTES);
  localparam int PAGE_BEATS_I = 4096 / BEAT_BYTES;
  localparam int CHP          = CH_W + 1;

  localparam logic [RBW-1:0]    GRP_BEATS  = RBW'(GRP_BEATS_I);
  localparam logic [7:0]        PAGE_BEATS = 8'(PAGE_BEATS_I);
  localparam logic [7:0]        MAX_B      = 8'(MAX_BURST);
  localparam logic [OW-1:0]     OUTST_C    = OW'(OUTST);
  localparam logic [OW-1:0]     OW_ONE     = OW'(1);
  localparam logic [CH_W-1:0]   CH_ONE     = CH_W'(1);
  localparam logic [ADDR_W-1:0] BEAT_ADDR  = ADDR_W'(BEAT_BYTES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_WT    = 3'd2,
    S_SC    = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              state_r;
  logic [ADDR_W-1:0]   addr_acc_r;
  logic [CH_W-1:0]     rows_r;
  logic [CH_W-1:0]     groups_r;
  logic [RBW-1:0]      last_beats_r;
  logic [RBW-1:0]      rb_r;
  logic [CH_W-1:0]     grp_r;
  logic [CH_W-1:0]     row_r;
  logic [OW-1:0]       outst_r;
  logic                cmd_valid_r;
  logic [ADDR_W-1:0]   cmd_addr_r;
  logic [7:0]          cmd_len_r;
  logic                cmd_is_scale_r;
  logic                cmd_last_r;
  logic                busy_r;
  logic                done_r;
  logic                err_r;

  logic [CHP-1:0]      chin_pad_s;
  logic [CH_W-1:0]     cfg_groups_s;
  logic [CH_W-1:0]     cfg_rem_s;
  logic [RBW-1:0]      cfg_last_s;
  logic [7:0]          page_left_s;
  logic [7:0]          rb8_s;
  logic [7:0]          cap_s;
  logic [7:0]          burst_s;
  logic                last_grp_s;
  logic                last_row_s;
  logic                next_grp_last_s;
  logic                acc_s;
  logic                resp_ok_s;
  logic [OW-1:0]       outst_nxt_s;
  logic                slot_s;

  // Decode group count and beats of the final (possibly partial) group from the raw config.
  always_comb begin
    chin_pad_s   = {1'b0, cfg_chin} + CHP'(GROUP_CH - 1);
    cfg_groups_s = CH_W'(chin_pad_s / CHP'(GROUP_CH));
    cfg_rem_s    = cfg_chin % CH_W'(GROUP_CH);
    if (cfg_rem_s == {CH_W{1'b0}}) begin
      cfg_last_s = GRP_BEATS;
    end else begin
      cfg_last_s = RBW'(cfg_rem_s / CH_W'(CH_PER_BEAT));
    end
  end

  // Size of the next weight burst and the group/row position flags.
  always_comb begin
    page_left_s     = PAGE_BEATS - 8'(addr_acc_r[11:OFF_LSB]);
    rb8_s           = 8'(rb_r);
    cap_s           = (rb8_s < MAX_B) ? rb8_s : MAX_B;
    burst_s         = (cap_s < page_left_s) ? cap_s : page_left_s;
    last_grp_s      = (grp_r == (groups_r - CH_ONE));
    last_row_s      = (row_r == (rows_r - CH_ONE));
    next_grp_last_s = ((grp_r + CH_ONE) == (groups_r - CH_ONE));
  end

  // Outstanding bookkeeping and whether a new command may be presented this edge.
  always_comb begin
    acc_s     = cmd_valid_r & cmd_if.cmd_ready;
    resp_ok_s = cmd_if.bresp_valid & (outst_r != {OW{1'b0}});
    case ({acc_s, resp_ok_s})
      2'b10:   outst_nxt_s = outst_r + OW_ONE;
      2'b01:   outst_nxt_s = outst_r - OW_ONE;
      default: outst_nxt_s = outst_r;
    endcase
    slot_s = (!cmd_valid_r || cmd_if.cmd_ready) && (outst_nxt_s < OUTST_C);
  end

  // Job sequencer: generates commands into the registered output slot and tracks completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= S_IDLE;
      addr_acc_r     <= {ADDR_W{1'b0}};
      rows_r         <= {CH_W{1'b0}};
      groups_r       <= {CH_W{1'b0}};
      last_beats_r   <= {RBW{1'b0}};
      rb_r           <= {RBW{1'b0}};
      grp_r          <= {CH_W{1'b0}};
      row_r          <= {CH_W{1'b0}};
      outst_r        <= {OW{1'b0}};
      cmd_valid_r    <= 1'b0;
      cmd_addr_r     <= {ADDR_W{1'b0}};
      cmd_len_r      <= 8'd0;
      cmd_is_scale_r <= 1'b0;
      cmd_last_r     <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      err_r          <= 1'b0;
    end else begin
      outst_r <= outst_nxt_s;
      done_r  <= 1'b0;
      if (acc_s) begin
        cmd_valid_r <= 1'b0;
      end
      case (state_r)
        S_IDLE: begin
          if (start) begin
            addr_acc_r   <= cfg_base;
            rows_r       <= cfg_rows;
            groups_r     <= cfg_groups_s;
            last_beats_r <= cfg_last_s;
            rb_r         <= (cfg_groups_s == CH_ONE) ? cfg_last_s : GRP_BEATS;
            grp_r        <= {CH_W{1'b0}};
            row_r        <= {CH_W{1'b0}};
            err_r        <= 1'b0;
            busy_r       <= 1'b1;
            state_r      <= S_SETUP;
          end
        end
        S_SETUP, S_WT: begin
          if (slot_s) begin
            cmd_valid_r    <= 1'b1;
            cmd_addr_r     <= addr_acc_r;
            cmd_len_r      <= burst_s - 8'd1;
            cmd_is_scale_r <= 1'b0;
            cmd_last_r     <= 1'b0;
            addr_acc_r     <= addr_acc_r + (ADDR_W'(burst_s) << OFF_LSB);
            rb_r           <= rb_r - RBW'(burst_s);
            state_r        <= (rb_r == RBW'(burst_s)) ? S_SC : S_WT;
          end
        end
        S_SC: begin
          if (slot_s) begin
            cmd_valid_r    <= 1'b1;
            cmd_addr_r     <= addr_acc_r;
            cmd_len_r      <= 8'd0;
            cmd_is_scale_r <= 1'b1;
            cmd_last_r     <= last_grp_s && last_row_s;
            addr_acc_r     <= addr_acc_r + BEAT_ADDR;
            if (!last_grp_s) begin
              grp_r   <= grp_r + CH_ONE;
              rb_r    <= next_grp_last_s ? last_beats_r : GRP_BEATS;
              state_r <= S_WT;
            end else if (!last_row_s) begin
              row_r   <= row_r + CH_ONE;
              grp_r   <= {CH_W{1'b0}};
              rb_r    <= (groups_r == CH_ONE) ? last_beats_r : GRP_BEATS;
              state_r <= S_WT;
            end else begin
              state_r <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if ((!cmd_valid_r || acc_s) && (outst_nxt_s == {OW{1'b0}})) begin
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= S_DONE;
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
      // Error responses and responses with nothing outstanding are sticky errors.
      if (cmd_if.bresp_valid && (cmd_if.bresp_err || (outst_r == {OW{1'b0}}))) begin
        err_r <= 1'b1;
      end
    end
  end

  assign cmd_if.cmd_valid    = cmd_valid_r;
  assign cmd_if.cmd_addr     = cmd_addr_r;
  assign cmd_if.cmd_len      = cmd_len_r;
  assign cmd_if.cmd_is_scale = cmd_is_scale_r;
  assign cmd_if.cmd_last     = cmd_last_r;
  assign busy                = busy_r;
  assign done                = done_r;
  assign err                 = err_r;

endmodule

// File: tb/tb_f2w_hbm_wr_sched.sv
// Self-checking bench for f2w_hbm_wr_sched. Expected command streams come from
// directed tables or from a loop-based layout model built from the row/group
// layout rules; a per-cycle driver applies random backpressure and responses.
module tb_f2w_hbm_wr_sched;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic        sc;
    logic        last;
  } cmd_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] cfg_base;
  logic [15:0] cfg_chin;
  logic [15:0] cfg_rows;
  logic        busy;
  logic        done;
  logic        err;

  int errors;
  int checks;
  cmd_t exp_q[$];

  f2w_hbm_wr_sched_if #(.ADDR_W(32)) bus ();

  f2w_hbm_wr_sched dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .cfg_base (cfg_base),
    .cfg_chin (cfg_chin),
    .cfg_rows (cfg_rows),
    .cmd_if   (bus),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void push(input logic [31:0] a, input logic [7:0] l, input logic s, input logic la);
    cmd_t c;
    c.addr = a; c.len = l; c.sc = s; c.last = la;
    exp_q.push_back(c);
  endfunction

  // Layout model: walk rows and groups, chop weight beats at 16 beats and 4 KB pages.
  function automatic void build_model(input logic [31:0] base, input int chin, input int rows);
    logic [31:0] a;
    int groups, beats, n, left, grp_ch;
    exp_q.delete();
    a = base;
    groups = (chin + 2047) / 2048;
    for (int r = 0; r < rows; r++) begin
      for (int g = 0; g < groups; g++) begin
        grp_ch = (g == groups - 1) ? (chin - g * 2048) : 2048;
        beats = grp_ch / 64;
        while (beats > 0) begin
          left = (4096 - int'(a[11:0])) / 32;
          n = beats;
          if (n > 16) n = 16;
          if (n > left) n = left;
          push(a, 8'(n - 1), 1'b0, 1'b0);
          a = a + 32'(n * 32);
          beats = beats - n;
        end
        push(a, 8'd0, 1'b1, (r == rows - 1) && (g == groups - 1));
        a = a + 32'd32;
      end
    end
  endfunction

  // Run one job against exp_q. rnd_ready: random backpressure; err_at: index of the
  // response carrying bresp_err (-1 none); stall: responses withheld until that cycle.
  task automatic run_job(input logic [31:0] base, input logic [15:0] chin, input logic [15:0] rows,
                         input bit rnd_ready, input int err_at, input int stall, input string tag);
    int pend, acc_cnt, resp_cnt, last_resp_cyc;
    bit pv, pr, fin;
    cmd_t pc, cur, e;
    pend = 0; acc_cnt = 0; resp_cnt = 0; last_resp_cyc = -10;
    pv = 1'b0; pr = 1'b0; fin = 1'b0; pc = '0;
    @(negedge clk);
    cfg_base = base; cfg_chin = chin; cfg_rows = rows; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || bus.cmd_valid !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL %s setup: busy=%b valid=%b err=%b, want busy=1 valid=0 err=0", tag, busy, bus.cmd_valid, err);
    end
    bus.cmd_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.bresp_valid = 1'b0; bus.bresp_err = 1'b0;
    pr = bus.cmd_ready;
    @(negedge clk);
    for (int cyc = 0; cyc < 5000 && !fin; cyc++) begin
      cur.addr = bus.cmd_addr; cur.len = bus.cmd_len; cur.sc = bus.cmd_is_scale; cur.last = bus.cmd_last;
      if (pv && pr) begin
        acc_cnt++; pend++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s extra_cmd: got addr=%h len=%0d sc=%b last=%b, want none", tag, pc.addr, pc.len, pc.sc, pc.last);
        end else begin
          e = exp_q.pop_front();
          if (pc !== e) begin
            errors++;
            $display("FAIL %s cmd%0d: got addr=%h len=%0d sc=%b last=%b, want addr=%h len=%0d sc=%b last=%b",
                     tag, acc_cnt - 1, pc.addr, pc.len, pc.sc, pc.last, e.addr, e.len, e.sc, e.last);
          end
        end
      end else if (pv && !pr) begin
        checks++;
        if (bus.cmd_valid !== 1'b1 || cur !== pc) begin
          errors++;
          $display("FAIL %s stable: got valid=%b addr=%h len=%0d, want valid=1 addr=%h len=%0d",
                   tag, bus.cmd_valid, cur.addr, cur.len, pc.addr, pc.len);
        end
      end
      if (cyc == 0) begin
        checks++;
        if (bus.cmd_valid !== 1'b1) begin
          errors++;
          $display("FAIL %s first_valid_latency: got valid=%b, want 1", tag, bus.cmd_valid);
        end
      end
      if (stall > 0 && cyc == stall) begin
        checks++;
        if (acc_cnt != 8 || bus.cmd_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s outst_limit: got accepted=%0d valid=%b, want accepted=8 valid=0", tag, acc_cnt, bus.cmd_valid);
        end
      end
      if (done === 1'b1) begin
        bus.bresp_valid = 1'b0; bus.bresp_err = 1'b0;
        checks++;
        if (exp_q.size() != 0 || pend != 0 || last_resp_cyc != cyc - 1) begin
          errors++;
          $display("FAIL %s done: got left=%0d pend=%0d resp_gap=%0d, want 0 0 1", tag, exp_q.size(), pend, cyc - last_resp_cyc);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL %s done_pulse: got done=%b busy=%b, want 0 0", tag, done, busy);
        end
        fin = 1'b1;
      end else begin
        bus.cmd_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (pend > 0 && cyc >= stall && $urandom_range(0, 2) != 0) begin
          bus.bresp_valid = 1'b1;
          bus.bresp_err = (resp_cnt == err_at);
          pend--; resp_cnt++; last_resp_cyc = cyc;
        end else begin
          bus.bresp_valid = 1'b0; bus.bresp_err = 1'b0;
        end
        pv = bus.cmd_valid; pr = bus.cmd_ready; pc = cur;
        @(negedge clk);
      end
    end
    bus.bresp_valid = 1'b0; bus.bresp_err = 1'b0; bus.cmd_ready = 1'b1;
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL %s timeout: got no done, want done", tag);
    end
    checks++;
    if (err !== (err_at >= 0)) begin
      errors++;
      $display("FAIL %s err_flag: got %b, want %b", tag, err, (err_at >= 0));
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; cfg_base = '0; cfg_chin = '0; cfg_rows = '0;
    bus.cmd_ready = 1'b1; bus.bresp_valid = 1'b0; bus.bresp_err = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.cmd_valid, bus.cmd_addr, bus.cmd_len, bus.cmd_is_scale, bus.cmd_last, busy, done, err} !== '0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b addr=%h len=%0d busy=%b done=%b err=%b, want all 0",
               bus.cmd_valid, bus.cmd_addr, bus.cmd_len, busy, done, err);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_group;
    exp_q.delete();
    push(32'h000, 8'd3, 1'b0, 1'b0);
    push(32'h080, 8'd0, 1'b1, 1'b1);
    run_job(32'h0, 16'd256, 16'd1, 1'b0, -1, 0, "single_group");
  endtask

  task automatic test_two_rows;
    exp_q.delete();
    push(32'h000, 8'd15, 1'b0, 1'b0); push(32'h200, 8'd15, 1'b0, 1'b0); push(32'h400, 8'd0, 1'b1, 1'b0);
    push(32'h420, 8'd15, 1'b0, 1'b0); push(32'h620, 8'd15, 1'b0, 1'b0); push(32'h820, 8'd0, 1'b1, 1'b1);
    run_job(32'h0, 16'd2048, 16'd2, 1'b0, -1, 0, "two_rows");
  endtask

  task automatic test_partial_group;
    exp_q.delete();
    push(32'h000, 8'd15, 1'b0, 1'b0); push(32'h200, 8'd15, 1'b0, 1'b0); push(32'h400, 8'd0, 1'b1, 1'b0);
    push(32'h420, 8'd3, 1'b0, 1'b0);  push(32'h4A0, 8'd0, 1'b1, 1'b1);
    run_job(32'h0, 16'd2304, 16'd1, 1'b1, -1, 0, "partial_group");
  endtask

  task automatic test_4k_split;
    exp_q.delete();
    push(32'hFC0, 8'd1, 1'b0, 1'b0); push(32'h1000, 8'd1, 1'b0, 1'b0); push(32'h1040, 8'd0, 1'b1, 1'b1);
    run_job(32'hFC0, 16'd256, 16'd1, 1'b0, -1, 0, "split_4k");
  endtask

  task automatic test_outst_limit;
    build_model(32'h0, 4096, 4);
    run_job(32'h0, 16'd4096, 16'd4, 1'b0, -1, 20, "outst_limit");
  endtask

  task automatic test_bresp_err;
    build_model(32'h2000, 2048, 1);
    run_job(32'h2000, 16'd2048, 16'd1, 1'b1, 1, 0, "bresp_err");
  endtask

  task automatic test_stray_bresp;
    @(negedge clk);
    bus.bresp_valid = 1'b1; bus.bresp_err = 1'b0;
    @(negedge clk);
    bus.bresp_valid = 1'b0;
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || bus.cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL stray_bresp: got err=%b busy=%b valid=%b, want 1 0 0", err, busy, bus.cmd_valid);
    end
  endtask

  task automatic test_reset_mid;
    bit seen, done_seen;
    seen = 1'b0; done_seen = 1'b0;
    @(negedge clk);
    cfg_base = 32'h0; cfg_chin = 16'd4096; cfg_rows = 16'd2; start = 1'b1; bus.cmd_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.cmd_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL reset_mid_start: got no cmd_valid, want cmd_valid");
    end
    bus.bresp_valid = 1'b1; bus.bresp_err = 1'b1;
    @(negedge clk);
    bus.bresp_valid = 1'b0; bus.bresp_err = 1'b0;
    checks++;
    if (err !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_err: got err=%b busy=%b, want 1 1", err, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.cmd_valid, bus.cmd_addr, bus.cmd_len, bus.cmd_is_scale, bus.cmd_last, busy, done, err} !== '0) begin
      errors++;
      $display("FAIL reset_mid_clear: got valid=%b addr=%h len=%0d busy=%b done=%b err=%b, want all 0",
               bus.cmd_valid, bus.cmd_addr, bus.cmd_len, busy, done, err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1 || bus.cmd_valid === 1'b1) done_seen = 1'b1;
    end
    checks++;
    if (done_seen) begin
      errors++;
      $display("FAIL reset_mid_quiet: got done/cmd_valid activity after reset, want none");
    end
    build_model(32'h0, 1024, 2);
    run_job(32'h0, 16'd1024, 16'd2, 1'b0, -1, 0, "after_reset");
  endtask

  task automatic test_random;
    logic [31:0] base;
    int chin, rows, ea;
    string tag;
    for (int it = 0; it < 8; it++) begin
      chin = 64 * $urandom_range(1, 128);
      rows = $urandom_range(1, 3);
      base = ($urandom & 32'hFFFF_F000) | 32'(32 * $urandom_range(0, 127));
      ea = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 1) : -1;
      build_model(base, chin, rows);
      tag = $sformatf("random%0d", it);
      run_job(base, 16'(chin), 16'(rows), 1'b1, ea, 0, tag);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single_group();
    test_two_rows();
    test_partial_group();
    test_4k_split();
    test_outst_limit();
    test_bresp_err();
    test_stray_bresp();
    test_two_rows();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/f2w_hbm_wr_sched.md
Name: f2w_hbm_wr_sched

Overview:
Write-command scheduler for the Feature2Weight-to-HBM path. It sequences the INT4 weight and FP16 scale write bursts for one converted weight matrix into HBM. Per output row, the layout is [WT group0 | scale0 | WT group1 | scale1 | ... | last partial WT group | last scale]. The same command is broadcast to all HBM ports in lockstep. It sits between the Feature2Weight quantizer (data side) and the HBM AXI write-address channels, and tracks write responses to signal completion.

Parameters:
ADDR_W, 32, HBM byte address width
CH_W, 16, width of CHin/row-count config fields
BEAT_BYTES, 32, HBM AXI beat size (256 b)
GROUP_CH, 2048, CHin per scale group (T_quant_block*256/16)
MAX_BURST, 16, max beats per command
OUTST, 8, max outstanding commands awaiting response

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle start pulse; sampled only in IDLE
cfg_base  in  ADDR_W  HBM base address, 32-byte aligned
cfg_chin  in  CH_W  CHin, padded; multiple of 64, nonzero
cfg_rows  in  CH_W  output rows per port (CHout_div_Tout*Tout/HBM_Port), nonzero
cmd_valid  out  1  command valid
cmd_ready  in  1  command accepted when valid&ready
cmd_addr  out  ADDR_W  burst start address
cmd_len  out  8  beats-1
cmd_is_scale  out  1  1 = scale beat, 0 = weight burst
cmd_last  out  1  final command of job
bresp_valid  in  1  one pulse per completed command (all ports merged)
bresp_err  in  1  error qualifier with bresp_valid
busy  out  1  job in progress
done  out  1  one-cycle pulse at job completion
err  out  1  sticky error; cleared on next accepted start

Behaviour:
- Reset (async): state IDLE; cmd_valid, cmd_addr, cmd_len, cmd_is_scale, cmd_last, busy, done, err all 0; all counters 0. Asserting reset mid-job drops the job with no done pulse.
- States: IDLE -> SETUP -> WT -> SC -> (WT | DRAIN) -> DONE -> IDLE.
- IDLE: start latches the config, clears err, sets busy, and moves to SETUP. start in any other state is ignored.
- SETUP (1 cycle):
  - groups = ceil(chin/GROUP_CH).
  - last_beats = (chin mod GROUP_CH)/64; if the remainder is 0, last_beats = GROUP_CH/64 = 32.
  - addr_acc = cfg_base; row = 0; grp = 0; remaining group beats rb = 32, or last_beats if groups = 1.
- WT: issue a weight command with len = min(rb, MAX_BURST, beats to the next 4 KB boundary) - 1.
  - On handshake: addr_acc += (len+1)*32; rb -= len+1.
  - When rb = 0, go to SC.
- SC: issue a scale command with len = 0 and cmd_is_scale = 1; addr_acc += 32. Then:
  - if grp < groups-1: grp++, set rb, go to WT;
  - else if row < cfg_rows-1: row++, grp = 0, reload rb, go to WT;
  - else the command carries cmd_last = 1 and the next state is DRAIN.
- The address stream is contiguous, so no explicit row stride is needed. Row stride equals chin/2 + 32*groups bytes by construction.
- Handshake rules:
  - cmd_* is registered and stays stable while cmd_valid & !cmd_ready.
  - The next command may be presented the cycle after acceptance; back-to-back issue is one command per cycle.
  - cmd_valid is withheld while outstanding = OUTST.
- Outstanding counter: +1 on accept, -1 on bresp_valid; both in the same cycle leaves it unchanged. A bresp_valid with outstanding = 0 is ignored and sets err.
- bresp_err sets err; the job continues to completion.
- DRAIN: wait for outstanding = 0, then DONE. DONE asserts done for 1 cycle, clears busy, and returns to IDLE.
- Latency: first cmd_valid appears 2 cycles after start (IDLE->SETUP->WT).

Test Plan:
- chin=256, rows=1, base=0, ready=1 -> cmds (0x000,len3,wt), (0x080,len0,scale,last). 2 bresp -> done 1 cycle after last bresp; err=0.
- chin=2048, rows=2, base=0 -> (0x000,15),(0x200,15),(0x400,scale),(0x420,15),(0x620,15),(0x820,scale,last).
- chin=2304, rows=1, base=0 -> (0x000,15),(0x200,15),(0x400,scale),(0x420,len3),(0x4A0,scale,last).
- 4 KB split: chin=256, base=0xFC0 -> (0xFC0,len1),(0x1000,len1),(0x1040,scale,last).
- Backpressure/limit: OUTST=8, chin=4096, rows=4, no bresp -> exactly 8 cmds accepted, then cmd_valid=0. cmd_ready toggled randomly -> fields stable while unaccepted. Releasing bresp resumes issue.
- Errors and reset: a bresp_err pulse -> err=1, job still completes and done pulses; err cleared by the next start. Reset asserted mid-WT -> all outputs 0 immediately; no done pulse; a new start works normally.
